// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 device: holds the clock line low to
// inhibit the device, issues request-to-send, shifts out 8 data bits
// (LSB first), odd parity and the stop bit on device-generated clock falls,
// then checks the device ack and waits for the bus to go idle.
//
// Both PS/2 lines are open-collector: the *_oe outputs pull the line low
// when high and release it when low.
//
// Optional feature: define PS2_TX_TIMEOUT_EN to add a watchdog that aborts
// the frame if the device does not finish within TIMEOUT_CYCLES clk cycles
// of request-to-send.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dato,
    input  logic       start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_e;

    // The inhibit counter only has to reach INHIBIT_CYCLES-1.
    localparam int unsigned     INH_W    = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    // The stop bit goes out on the tenth clock fall.
    localparam logic [3:0] LAST_EDGE = 4'd9;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e           state_q, state_d;

    logic             clk_meta_q,  clk_meta_d;
    logic             clk_sync_q,  clk_sync_d;
    logic             clk_prev_q,  clk_prev_d;
    logic             data_meta_q, data_meta_d;
    logic             data_sync_q, data_sync_d;

    logic [INH_W-1:0] inh_cnt_q,   inh_cnt_d;
    logic [3:0]       bit_cnt_q,   bit_cnt_d;
    // Frame image {stop, parity, data[7:0], start}; bit 0 is on the wire.
    logic [10:0]      sr_q,        sr_d;

    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             error_q,     error_d;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned    WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_active;
    logic            wd_expire;
`endif

    // Events derived from the synchronized bus lines.
    logic clk_fall;
    logic ack_fail;
    logic frame_done;

    assign clk_fall   = clk_prev_q & ~clk_sync_q;
    assign ack_fail   = (state_q == S_ACK) & clk_fall & data_sync_q;
    assign frame_done = (state_q == S_WAIT_IDLE) & clk_sync_q & data_sync_q;

`ifdef PS2_TX_TIMEOUT_EN
    // The watchdog runs from request-to-send until the frame resolves.
    assign wd_active = (state_q == S_RTS) | (state_q == S_SHIFT) |
                       (state_q == S_ACK) | (state_q == S_WAIT_IDLE);
    assign wd_expire = wd_active & (wd_cnt_q == WD_LAST);
`endif

    // State register and all datapath flops; reset wins over any pending start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop, as hardware does.
        if (reset) begin
            state_q     <= S_IDLE;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            inh_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            inh_cnt_q   <= inh_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q    <= wd_cnt_d;
`endif
        end
    end

    // Next-state logic for the transmit sequence.
    always_comb begin
        // NOTE: a default assignment before the case keeps every path
        // assigned, so no latch is inferred for state_d.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (start) state_d = S_INHIBIT;
            S_INHIBIT:   if (inh_cnt_q == INH_LAST) state_d = S_RTS;
            S_RTS:       state_d = S_SHIFT;
            S_SHIFT:     if (clk_fall && (bit_cnt_q == LAST_EDGE)) state_d = S_ACK;
            S_ACK:       if (clk_fall) state_d = data_sync_q ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (clk_sync_q && data_sync_q) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        // A frame that completes on the expiry cycle still counts as done.
        if (wd_expire && !frame_done) state_d = S_IDLE;
`endif
    end

    // Datapath: synchronizers, counters, frame shifter and status flags.
    always_comb begin
        clk_meta_d  = ps2_clk_in;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = ps2_data_in;
        data_sync_d = data_meta_q;

        inh_cnt_d = '0;
        if ((state_q == S_INHIBIT) && (inh_cnt_q != INH_LAST)) begin
            inh_cnt_d = inh_cnt_q + INH_W'(1);
        end

        bit_cnt_d = bit_cnt_q;
        if (state_q == S_IDLE) begin
            bit_cnt_d = '0;
        end else if ((state_q == S_SHIFT) && clk_fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        sr_d = sr_q;
        if ((state_q == S_IDLE) && start) begin
            // Odd parity: the parity bit makes the 9-bit total odd.
            sr_d = {1'b1, ~^dato, dato, 1'b0};
        end else if ((state_q == S_SHIFT) && clk_fall) begin
            sr_d = {1'b1, sr_q[10:1]};
        end

        busy_d  = (state_d != S_IDLE);
        done_d  = frame_done;
        error_d = ack_fail;
`ifdef PS2_TX_TIMEOUT_EN
        error_d = ack_fail | (wd_expire & ~frame_done);

        wd_cnt_d = '0;
        if (wd_active && !wd_expire) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
    end

    // Line drivers decoded from the current state.
    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        unique case (state_q)
            S_INHIBIT: ps2_clk_oe  = 1'b1;
            S_RTS:     ps2_data_oe = ~sr_q[0];
            S_SHIFT:   ps2_data_oe = ~sr_q[0];
            default: begin
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
            end
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed plus randomized bench for ps2_host_tx with a
// behavioural PS/2 device that generates the clock, samples host bits just
// before each rising edge and optionally drives the ack bit.
module tb_ps2_host_tx;

    localparam int INH = 16;
    localparam int TO  = 3000;
    localparam int HP  = 8;    // device half-period in clk cycles

    logic       clk;
    logic       reset;
    logic [7:0] dato;
    logic       start;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;

    logic dev_clk_low;
    logic dev_data_low;

    // Wired-AND open-collector bus with pull-ups.
    assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dato       (dato),
        .start      (start),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Pulse bookkeeping sampled mid-cycle.
    int   done_seen  = 0;
    int   err_seen   = 0;
    int   overlap    = 0;
    int   long_pulse = 0;
    logic done_prev  = 1'b0;
    logic err_prev   = 1'b0;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (error === 1'b1) err_seen++;
        if ((done === 1'b1) && (error === 1'b1)) overlap++;
        if (((done === 1'b1) && (done_prev === 1'b1)) ||
            ((error === 1'b1) && (err_prev === 1'b1))) long_pulse++;
        done_prev = done;
        err_prev  = error;
    end

    logic [10:0] got_bits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected wire image: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[k+1] = b[k];
        f[9]  = (($countones(b) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_start(input logic [7:0] b);
        dato  = b;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        dato  = 8'($urandom);
    endtask

    // Count inhibit cycles until request-to-send appears; sample the start bit.
    task automatic wait_rts(input string tag);
        int inh  = 0;
        bit seen = 1'b0;
        for (int i = 0; (i < INH + 64) && !seen; i++) begin
            if (ps2_data_oe === 1'b1) seen = 1'b1;
            else begin
                if (ps2_clk_oe === 1'b1) inh++;
                tick(1);
            end
        end
        check({tag, "_rts_seen"}, 32'(seen), 32'd1);
        check({tag, "_inhibit_len"}, 32'(inh), 32'(INH));
        check({tag, "_rts_clk_rel"}, 32'(ps2_clk_oe), 32'd0);
        got_bits[0] = ps2_data_in;
    endtask

    // Device clocks falls [first..last]; fall 11 is the ack slot.
    task automatic clock_edges(input int first, input int last, input bit ack);
        for (int i = first; i <= last; i++) begin
            if ((i == 11) && ack) dev_data_low = 1'b1;
            tick(HP);
            dev_clk_low = 1'b1;
            tick(HP);
            if (i <= 10) got_bits[i] = ps2_data_in;
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic full_frame(input logic [7:0] b, input bit ack, input string tag);
        int d0;
        int e0;
        d0 = done_seen;
        e0 = err_seen;
        send_start(b);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_rts(tag);
        clock_edges(1, 11, ack);
        tick(HP);
        check({tag, "_frame"}, 32'(got_bits), 32'(model_frame(b)));
        check({tag, "_done_cnt"}, 32'(done_seen - d0), 32'(ack));
        check({tag, "_err_cnt"}, 32'(err_seen - e0), 32'(!ack));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_oe_end"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        int n;
        logic [7:0] a;

        reset        = 1'b1;
        start        = 1'b0;
        dato         = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        got_bits     = '0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state.
        check("rst_clk_oe",  32'(ps2_clk_oe),  32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_done",    32'(done),        32'd0);
        check("rst_error",   32'(error),       32'd0);

        // Known command bytes.
        full_frame(8'hED, 1'b1, "ed");
        check("ed_parity", 32'(got_bits[9]), 32'd1);
        full_frame(8'hF4, 1'b1, "f4");
        check("f4_parity", 32'(got_bits[9]), 32'd0);

        // Missing ack.
        full_frame(8'($urandom), 1'b0, "nack");

        // Reset in the middle of a frame, then a clean 0xFF frame.
        send_start(8'($urandom));
        wait_rts("mid");
        clock_edges(1, 4, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_oe",   {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        full_frame(8'hFF, 1'b1, "ff");
        check("ff_parity", 32'(got_bits[9]), 32'd1);

        // Reset and start in the same cycle: start discarded.
        reset = 1'b1;
        start = 1'b1;
        dato  = 8'h5A;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        check("rststart_busy", 32'(busy), 32'd0);
        tick(3);
        check("rststart_clk_oe", 32'(ps2_clk_oe), 32'd0);

        // Start during SHIFT is ignored.
        a  = 8'($urandom);
        d0 = done_seen;
        send_start(a);
        wait_rts("ign");
        clock_edges(1, 3, 1'b0);
        send_start(8'h00);
        check("ign_busy", 32'(busy), 32'd1);
        clock_edges(4, 11, 1'b1);
        tick(HP);
        check("ign_frame", 32'(got_bits), 32'(model_frame(a)));
        check("ign_done", 32'(done_seen - d0), 32'd1);

        // Randomized frames, mostly acked.
        for (int r = 0; r < 6; r++) begin
            full_frame(8'($urandom), ($urandom_range(0, 3) != 0), $sformatf("rnd%0d", r));
        end

        // Device never clocks.
        e0 = err_seen;
        send_start(8'($urandom));
        wait_rts("to");
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while ((error !== 1'b1) && (n < TO + 64)) begin
            tick(1);
            n++;
        end
        check("to_latency", 32'(n), 32'(TO));
        check("to_busy", 32'(busy), 32'd0);
        check("to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        tick(2);
        check("to_err_cnt", 32'(err_seen - e0), 32'd1);
`else
        n = 0;
        tick(TO + 64);
        check("to_busy_hold", 32'(busy), 32'd1);
        check("to_no_err", 32'(err_seen - e0 + n), 32'd0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("to_rst_busy", 32'(busy), 32'd0);
`endif

        tick(4);
        check("no_overlap", 32'(overlap), 32'd0);
        check("pulse_width", 32'(long_pulse), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter: INHIBIT_CYCLES, 10000, clk cycles the PS/2 clock line is held low before request-to-send (100 us at 100 MHz).
REQ-002 Parameter: TIMEOUT_CYCLES, 2000000, watchdog limit in clk cycles from end of inhibit to frame completion (20 ms at 100 MHz).
REQ-003 clk  input  1  system clock; every flop is on its rising edge; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dato  input  8  command byte to send to the device; sampled on the accepted start.
REQ-006 start  input  1  one-cycle request to transmit dato.
REQ-007 ps2_clk_in  input  1  raw PS/2 clock line level, asynchronous.
REQ-008 ps2_data_in  input  1  raw PS/2 data line level, asynchronous.
REQ-009 ps2_clk_oe  output  1  1 = drive PS/2 clock low; 0 = release (open-collector).
REQ-010 ps2_data_oe  output  1  1 = drive PS/2 data low; 0 = release.
REQ-011 busy  output  1  high from the accepted start until done or error.
REQ-012 done  output  1  one-cycle pulse: frame sent and device ack received.
REQ-013 error  output  1  one-cycle pulse: ack missing or watchdog expired.

Function
REQ-014 ps2_clk_in and ps2_data_in shall pass through 2-flop synchronizers; a falling edge is synchronized clock 1 -> 0 between consecutive cycles.
REQ-015 States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-016 IDLE: start=1 latches dato into a shift register, computes odd parity, sets busy, and moves to INHIBIT on the next cycle.
REQ-017 start while busy=1 shall be ignored; dato is not re-sampled.
REQ-018 INHIBIT: ps2_clk_oe=1 and ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-019 RTS: ps2_data_oe=1 (start bit 0) and ps2_clk_oe=0 in the same cycle, then SHIFT.
REQ-020 SHIFT: falling edges 1-8 put data bits 0-7 (LSB first), edge 9 the parity bit, edge 10 the stop bit (release); ps2_data_oe = NOT(bit); edge 10 moves to ACK.
REQ-021 Parity bit = 1 when dato has an even number of ones (odd parity over 9 bits).
REQ-022 ACK: on the next falling edge, synchronized data=0 -> WAIT_IDLE; data=1 -> error pulse, IDLE.
REQ-023 WAIT_IDLE: once synchronized clock and data are both 1, a done pulse fires, busy drops, and the state returns to IDLE in the same cycle.
REQ-024 A bit counter (4 bits) counts falling edges in SHIFT; no other event advances it.
REQ-025 Output rules: ps2_data_oe=0 in IDLE, INHIBIT, ACK and WAIT_IDLE; ps2_clk_oe=1 only in INHIBIT.
REQ-026 done and error shall never be high in the same cycle; each lasts exactly one cycle.

Reset
REQ-027 reset=1 in any state, including mid-frame, shall on the next edge force IDLE with ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, counters=0.
REQ-028 If reset and start are high in the same cycle, reset wins and the start is discarded.

Configuration
REQ-029 Macro PS2_TX_TIMEOUT_EN: when defined, a watchdog counts from RTS entry; reaching TIMEOUT_CYCLES before done releases both lines, pulses error, and returns to IDLE. If the timeout and the ack check resolve in the same cycle, error pulses once. When undefined, the watchdog logic is absent and error comes only from REQ-022.

Verification
REQ-030 start with dato=8'hED, device model clocks and acks -> bits 1,0,1,1,0,1,1,1, parity 1, stop released; done pulses once; busy drops.
REQ-031 dato=8'hF4 -> parity bit 0; ps2_clk_oe high for exactly INHIBIT_CYCLES cycles before ps2_data_oe rises.
REQ-032 Device leaves data high on the 11th falling edge -> error pulse, no done, lines released, IDLE.
REQ-033 reset pulsed after the 4th falling edge -> both oe=0 on the next cycle; a new start with 8'hFF completes normally (parity 1).
REQ-034 start pulsed again during SHIFT with dato=8'h00 -> ignored; transmitted bits still match the first byte.
REQ-035 With PS2_TX_TIMEOUT_EN, device never clocks -> error exactly TIMEOUT_CYCLES after RTS entry; without the macro, busy stays high.
